icache_op_issue: RTL and testbench

Sequencer for CACHE instructions that target the I-cache. It sits in the memory stage, directly upstream of the instruction-request selector. It latches one I-cache operation and drives the cache-op request port (req/addr_ok/data_ok) through the selector. It also produces the `icache_op` steering bits that the selector uses to share the ibus with fetch, and reports completion, TLB exceptions or stall to the pipeline.

---
 rtl/icache_op_issue_if.sv | 21 ++
 rtl/icache_op_issue.sv | 105 ++++++++++
 tb/tb_icache_op_issue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_op_issue_if.sv
// Cache-op request/response port between the I-cache op sequencer and the
// instruction-request selector (request side plus TLB result for the op).
interface icache_op_issue_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [1:0]  req_op;
    logic        addr_ok;
    logic        data_ok;
    logic        tlb_refill;
    logic        tlb_invalid;

    modport master (
        output req_valid, req_addr, req_op,
        input  addr_ok, data_ok, tlb_refill, tlb_invalid
    );

    modport slave (
        input  req_valid, req_addr, req_op,
        output addr_ok, data_ok, tlb_refill, tlb_invalid
    );
endinterface

// File: rtl/icache_op_issue.sv
// Memory-stage sequencer for I-cache CACHE instructions: issues one op on the
// cache-op port, steers the ibus via icache_op, and reports done/exception/stall.
module icache_op_issue (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [31:0]         vaddr,
    icache_op_issue_if.master   cop,
    output logic [1:0]          icache_op,
    output logic                busy,
    output logic                done,
    output logic                exc_valid,
    output logic                exc_refill,
    output logic [31:0]         badvaddr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        EXC   = 3'd5
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] addr_reg;
    logic [1:0]  op_reg;
    logic        req_valid_reg;
    logic [1:0]  icache_op_reg;
    logic        done_reg;
    logic        exc_valid_reg;
    logic        exc_refill_reg;
    logic        accept;
    logic        tlb_fault;

    assign accept    = (state_reg == IDLE) && start && !flush;
    // Only hit-type ops translate, so index ops never fault.
    assign tlb_fault = op_reg[1] && (cop.tlb_refill || cop.tlb_invalid);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = REQ;
            REQ: begin
                if (cop.addr_ok) begin
                    if (tlb_fault)  state_next = EXC;
                    else if (flush) state_next = DRAIN;
                    else            state_next = WAIT;
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cop.data_ok)  state_next = flush ? IDLE : DONE;
                else if (flush)   state_next = DRAIN;
            end
            // An issued op must still complete in the cache before the ibus is released.
            DRAIN: if (cop.data_ok) state_next = IDLE;
            DONE:  state_next = IDLE;
            EXC:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            addr_reg       <= 32'h0;
            op_reg         <= 2'b00;
            req_valid_reg  <= 1'b0;
            icache_op_reg  <= 2'b00;
            done_reg       <= 1'b0;
            exc_valid_reg  <= 1'b0;
            exc_refill_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_valid_reg  <= (state_next == REQ);
            icache_op_reg  <= {(state_next == REQ) || (state_next == WAIT) || (state_next == DRAIN),
                               (state_next == WAIT) || (state_next == DRAIN)};
            done_reg       <= (state_next == DONE);
            exc_valid_reg  <= (state_next == EXC);
            // EXC is entered only from REQ on addr_ok, so this captures the flag at addr_ok.
            exc_refill_reg <= (state_next == EXC) && cop.tlb_refill;
            if (accept) begin
                addr_reg <= vaddr;
                op_reg   <= op;
            end
        end
    end

    assign cop.req_valid = req_valid_reg;
    assign cop.req_addr  = addr_reg;
    assign cop.req_op    = op_reg;
    assign icache_op     = icache_op_reg;
    assign busy          = accept || icache_op_reg[1];
    assign done          = done_reg;
    assign exc_valid     = exc_valid_reg;
    assign exc_refill    = exc_refill_reg;
    assign badvaddr      = addr_reg;

endmodule

// File: tb/tb_icache_op_issue.sv
// Directed bench for icache_op_issue: normal, exception, flush and reset
// sequences with hand-derived per-cycle expectations.
module tb_icache_op_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] vaddr;
    logic [1:0]  icache_op;
    logic        busy;
    logic        done;
    logic        exc_valid;
    logic        exc_refill;
    logic [31:0] badvaddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_op_issue_if bus ();

    icache_op_issue dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .start      (start),
        .op         (op),
        .vaddr      (vaddr),
        .cop        (bus.master),
        .icache_op  (icache_op),
        .busy       (busy),
        .done       (done),
        .exc_valid  (exc_valid),
        .exc_refill (exc_refill),
        .badvaddr   (badvaddr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let freshly driven inputs settle, then check the status outputs.
    task automatic expect_out(input string tag, input logic rv, input logic [1:0] iop,
                              input logic bsy, input logic dn, input logic exc);
        #1;
        chk({tag, " req_valid"}, bus.req_valid, rv);
        chk({tag, " icache_op"}, icache_op, iop);
        chk({tag, " busy"}, busy, bsy);
        chk({tag, " done"}, done, dn);
        chk({tag, " exc_valid"}, exc_valid, exc);
    endtask

    task automatic run_exc(input string tag, input logic [1:0] o, input logic [31:0] va,
                           input logic rf, input logic inv, input logic exp_rf);
        cyc(); start = 1'b1; op = o; vaddr = va;
        expect_out({tag, " c0"}, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; bus.addr_ok = 1'b1; bus.tlb_refill = rf; bus.tlb_invalid = inv;
        expect_out({tag, " c1"}, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(); bus.addr_ok = 1'b0; bus.tlb_refill = 1'b0; bus.tlb_invalid = 1'b0;
        expect_out({tag, " c2"}, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk({tag, " exc_refill"}, exc_refill, exp_rf);
        chk({tag, " badvaddr"}, badvaddr, va);
        cyc();
        expect_out({tag, " c3"}, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("txn %s op=%b vaddr=%08h refill=%b invalid=%b", tag, o, va, rf, inv);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00; vaddr = 32'h0;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.tlb_refill = 1'b0; bus.tlb_invalid = 1'b0;

        // Reset state
        cyc(); cyc();
        expect_out("rst", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst req_addr", bus.req_addr, 32'h0);
        chk("rst req_op", {30'h0, bus.req_op}, 32'h0);
        chk("rst exc_refill", exc_refill, 1'b0);
        chk("rst badvaddr", badvaddr, 32'h0);
        reset = 1'b1;
        $display("txn reset");

        // Index-invalidate, addr_ok in cycle 1, data_ok in cycle 3
        cyc(); start = 1'b1; op = 2'b00; vaddr = 32'h8000_1000;
        expect_out("t1 c0", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; vaddr = 32'hDEAD_BEEF; bus.addr_ok = 1'b1;
        expect_out("t1 c1", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("t1 req_addr", bus.req_addr, 32'h8000_1000);
        chk("t1 req_op", {30'h0, bus.req_op}, 32'h0);
        cyc(); bus.addr_ok = 1'b0;
        expect_out("t1 c2", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); bus.data_ok = 1'b1;
        expect_out("t1 c3", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); bus.data_ok = 1'b0;
        expect_out("t1 c4", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("t1 c5", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("txn index-invalidate vaddr=80001000");

        // Hit-invalidate with TLB refill at addr_ok in cycle 2
        cyc(); start = 1'b1; op = 2'b10; vaddr = 32'h0040_0000;
        expect_out("t2 c0", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0;
        expect_out("t2 c1", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(); bus.addr_ok = 1'b1; bus.tlb_refill = 1'b1;
        expect_out("t2 c2", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(); bus.addr_ok = 1'b0; bus.tlb_refill = 1'b0;
        expect_out("t2 c3", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t2 exc_refill", exc_refill, 1'b1);
        chk("t2 badvaddr", badvaddr, 32'h0040_0000);
        cyc();
        expect_out("t2 c4", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("txn hit-invalidate tlb refill vaddr=00400000");

        // Minimum-latency exceptions: invalid-only, and both flags (refill wins)
        run_exc("t2b", 2'b10, 32'h1000_2000, 1'b0, 1'b1, 1'b0);
        run_exc("t2c", 2'b11, 32'h2000_3004, 1'b1, 1'b1, 1'b1);

        // Index-store-tag ignores tlb_invalid
        cyc(); start = 1'b1; op = 2'b01; vaddr = 32'h1234_5670;
        expect_out("t3 c0", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; bus.addr_ok = 1'b1; bus.tlb_invalid = 1'b1;
        expect_out("t3 c1", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(); bus.addr_ok = 1'b0; bus.tlb_invalid = 1'b0; bus.data_ok = 1'b1;
        expect_out("t3 c2", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); bus.data_ok = 1'b0;
        expect_out("t3 c3", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("t3 req_op", {30'h0, bus.req_op}, 32'h1);
        $display("txn index-store-tag tlb invalid ignored");

        // start with flush in IDLE is not accepted
        cyc(); start = 1'b1; flush = 1'b1; vaddr = 32'h5555_0000;
        expect_out("t4a c0", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(); start = 1'b0; flush = 1'b0;
        expect_out("t4a c1", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("txn start+flush in idle");

        // Flush in REQ before addr_ok
        cyc(); start = 1'b1; op = 2'b00; vaddr = 32'h0000_8000;
        expect_out("t4 c0", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; flush = 1'b1;
        expect_out("t4 c1", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(); flush = 1'b0;
        expect_out("t4 c2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_out("t4 c3", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("txn flush in REQ");

        // Flush in WAIT, data_ok four cycles later, flush again in DRAIN
        cyc(); start = 1'b1; op = 2'b00; vaddr = 32'h0000_C000;
        expect_out("t5 c0", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; bus.addr_ok = 1'b1;
        expect_out("t5 c1", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(); bus.addr_ok = 1'b0; flush = 1'b1;
        expect_out("t5 c2", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); flush = 1'b0;
        expect_out("t5 c3", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); flush = 1'b1;
        expect_out("t5 c4", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); flush = 1'b0;
        expect_out("t5 c5", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); bus.data_ok = 1'b1;
        expect_out("t5 c6", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        cyc(); bus.data_ok = 1'b0;
        expect_out("t5 c7", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_out("t5 c8", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("txn flush in WAIT with drain");

        // Reset while in WAIT, then a fresh request
        cyc(); start = 1'b1; op = 2'b00; vaddr = 32'hA000_0040;
        expect_out("t6 c0", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; bus.addr_ok = 1'b1;
        expect_out("t6 c1", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc(); bus.addr_ok = 1'b0;
        expect_out("t6 c2", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(); reset = 1'b1;
        expect_out("t6 c3", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("t6 req_addr", bus.req_addr, 32'h0);
        chk("t6 exc_refill", exc_refill, 1'b0);
        cyc(); start = 1'b1; op = 2'b01; vaddr = 32'hB000_0080;
        expect_out("t6 c4", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; bus.addr_ok = 1'b1;
        expect_out("t6 c5", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("t6 new req_addr", bus.req_addr, 32'hB000_0080);
        chk("t6 new req_op", {30'h0, bus.req_op}, 32'h1);
        cyc(); bus.addr_ok = 1'b0; bus.data_ok = 1'b1;
        expect_out("t6 c6", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        $display("txn reset in WAIT then fresh request");

        // start during DONE is not sampled; accepted the next cycle
        cyc(); bus.data_ok = 1'b0; start = 1'b1; op = 2'b10; vaddr = 32'hC000_0100;
        expect_out("t7 c0", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("t7 c1", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(); start = 1'b0; flush = 1'b1;
        expect_out("t7 c2", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("t7 req_addr", bus.req_addr, 32'hC000_0100);
        cyc(); flush = 1'b0;
        expect_out("t7 c3", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        $display("txn back-to-back start after DONE");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
